// File: rtl/ep_result_writeback.sv
// ep_result_writeback: even-pipe result shift pipe with in-order
// register-file writeback and three-port operand forwarding.
module ep_result_writeback #(
    parameter int DEPTH  = 7,
    parameter int DATA_W = 128,
    parameter int ADDR_W = 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [0:DATA_W-1] in_rt_value,
    input  logic [0:ADDR_W-1] in_rt_addr,
    input  logic [0:3]        in_latency,
    input  logic [0:2]        in_unit_id,
    input  logic              flush,
    input  logic [0:ADDR_W-1] qa_addr,
    input  logic [0:ADDR_W-1] qb_addr,
    input  logic [0:ADDR_W-1] qc_addr,
    output logic              qa_hit,
    output logic              qb_hit,
    output logic              qc_hit,
    output logic [0:DATA_W-1] qa_data,
    output logic [0:DATA_W-1] qb_data,
    output logic [0:DATA_W-1] qc_data,
    output logic              qa_stall,
    output logic              qb_stall,
    output logic              qc_stall,
    output logic              wb_en,
    output logic [0:ADDR_W-1] wb_addr,
    output logic [0:DATA_W-1] wb_data,
    output logic [0:2]        wb_unit_id,
    output logic [0:3]        occupancy,
    output logic              lat_err
);

    localparam logic [0:3] MAX_LAT = 4'(DEPTH);

    typedef struct packed {
        logic              valid;
        logic [0:DATA_W-1] value;
        logic [0:ADDR_W-1] addr;
        logic [0:3]        lat;
        logic [0:2]        unit_id;
    } entry_t;

    entry_t            stage [1:DEPTH];
    entry_t            in_entry;
    logic              lat_bad;
    logic              kill [1:DEPTH];
    logic [0:3]        occ_next;
    logic [0:ADDR_W-1] q_addr  [3];
    logic              q_found [3];
    logic              q_ready [3];
    logic [0:DATA_W-1] q_value [3];

    // A flush cycle drops the incoming result outright.
    always_comb begin
        in_entry.valid   = in_valid & ~flush;
        in_entry.value   = in_rt_value;
        in_entry.addr    = in_rt_addr;
        in_entry.lat     = in_latency;
        in_entry.unit_id = in_unit_id;
        lat_bad          = 1'b0;
        if (in_latency == 4'd0) begin
            in_entry.lat = 4'd1;
            lat_bad      = 1'b1;
        end else if (in_latency > MAX_LAT) begin
            in_entry.lat = MAX_LAT;
            lat_bad      = 1'b1;
        end
    end

    // Stage DEPTH is always ready, so flush never kills a retiring entry.
    always_comb begin
        occ_next = occupancy;
        if (in_entry.valid)
            occ_next = occ_next + 4'd1;
        if (stage[DEPTH].valid)
            occ_next = occ_next - 4'd1;
        for (int k = 1; k <= DEPTH; k++) begin
            kill[k] = flush && stage[k].valid && (4'(k) < stage[k].lat);
            if (kill[k])
                occ_next = occ_next - 4'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 1; k <= DEPTH; k++)
                stage[k] <= '0;
            occupancy <= '0;
            lat_err   <= 1'b0;
        end else begin
            stage[1] <= in_entry;
            for (int k = 2; k <= DEPTH; k++) begin
                stage[k] <= stage[k-1];
                if (kill[k-1])
                    stage[k].valid <= 1'b0;
            end
            occupancy <= occ_next;
            lat_err   <= in_valid & lat_bad;
        end
    end

    assign wb_en      = stage[DEPTH].valid;
    assign wb_addr    = stage[DEPTH].addr;
    assign wb_unit_id = stage[DEPTH].unit_id;
    assign wb_data    = stage[DEPTH].valid ? stage[DEPTH].value : '0;

    assign q_addr[0] = qa_addr;
    assign q_addr[1] = qb_addr;
    assign q_addr[2] = qc_addr;

    // Scan oldest to youngest so the youngest match wins; an unready
    // youngest match hides any older ready one.
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            q_found[p] = 1'b0;
            q_ready[p] = 1'b0;
            q_value[p] = '0;
            for (int k = DEPTH; k >= 1; k--) begin
                if (stage[k].valid && stage[k].addr == q_addr[p]) begin
                    q_found[p] = 1'b1;
                    q_ready[p] = 4'(k) >= stage[k].lat;
                    q_value[p] = stage[k].value;
                end
            end
        end
    end

    assign qa_hit   = q_found[0] & q_ready[0];
    assign qb_hit   = q_found[1] & q_ready[1];
    assign qc_hit   = q_found[2] & q_ready[2];
    assign qa_stall = q_found[0] & ~q_ready[0];
    assign qb_stall = q_found[1] & ~q_ready[1];
    assign qc_stall = q_found[2] & ~q_ready[2];
    assign qa_data  = qa_hit ? q_value[0] : '0;
    assign qb_data  = qb_hit ? q_value[1] : '0;
    assign qc_data  = qc_hit ? q_value[2] : '0;

endmodule

// File: tb/tb_ep_result_writeback.sv
// Bench for ep_result_writeback: directed table, corner sequences and
// random traffic against an age-based in-flight result model.
module tb_ep_result_writeback;

    localparam int DEPTH = 7;

    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [0:127] in_rt_value;
    logic [0:6]   in_rt_addr;
    logic [0:3]   in_latency;
    logic [0:2]   in_unit_id;
    logic         flush;
    logic [0:6]   qa_addr, qb_addr, qc_addr;
    logic         qa_hit, qb_hit, qc_hit;
    logic [0:127] qa_data, qb_data, qc_data;
    logic         qa_stall, qb_stall, qc_stall;
    logic         wb_en;
    logic [0:6]   wb_addr;
    logic [0:127] wb_data;
    logic [0:2]   wb_unit_id;
    logic [0:3]   occupancy;
    logic         lat_err;

    always #5 clock = ~clock;

    ep_result_writeback dut (
        .clock(clock), .reset(reset), .in_valid(in_valid),
        .in_rt_value(in_rt_value), .in_rt_addr(in_rt_addr),
        .in_latency(in_latency), .in_unit_id(in_unit_id), .flush(flush),
        .qa_addr(qa_addr), .qb_addr(qb_addr), .qc_addr(qc_addr),
        .qa_hit(qa_hit), .qb_hit(qb_hit), .qc_hit(qc_hit),
        .qa_data(qa_data), .qb_data(qb_data), .qc_data(qc_data),
        .qa_stall(qa_stall), .qb_stall(qb_stall), .qc_stall(qc_stall),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .wb_unit_id(wb_unit_id), .occupancy(occupancy), .lat_err(lat_err)
    );

    typedef struct {
        bit           rst;
        bit           v;
        logic [127:0] val;
        logic [6:0]   addr;
        logic [3:0]   lat;
        logic [2:0]   uid;
        bit           fl;
        logic [6:0]   qa, qb, qc;
    } stim_t;

    typedef struct {
        int           t;
        logic [127:0] val;
        logic [6:0]   addr;
        int           lat;
        logic [2:0]   uid;
    } ent_t;

    typedef struct {
        bit v;
        bit hit;
        bit stall;
        bit wb;
        int occ;
    } row_t;

    ent_t  mq[$];
    int    cyc = 0;
    int    exp_occ = 0;
    bit    exp_lerr = 0;
    int    n_cmp = 0;
    int    n_bad = 0;
    stim_t cur;

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic stim_t push(logic [6:0] a, logic [3:0] l,
                                   logic [127:0] val, logic [2:0] u);
        stim_t s;
        s = idle();
        s.v = 1; s.addr = a; s.lat = l; s.val = val; s.uid = u;
        return s;
    endfunction

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h",
                     nm, cyc, act, exp);
        end
    endtask

    // Youngest in-flight result for an address decides hit or stall.
    task automatic model_check();
        bit           en;
        logic [127:0] d;
        logic [6:0]   a;
        logic [2:0]   u;
        en = 0; d = '0; a = '0; u = '0;
        foreach (mq[i])
            if (cyc - mq[i].t == DEPTH) begin
                en = 1; d = mq[i].val; a = mq[i].addr; u = mq[i].uid;
            end
        chk("wb_en", 128'(wb_en), 128'(en));
        chk("wb_data", 128'(wb_data), d);
        if (en) begin
            chk("wb_addr", 128'(wb_addr), 128'(a));
            chk("wb_unit_id", 128'(wb_unit_id), 128'(u));
        end
        chk("occupancy", 128'(occupancy), 128'(exp_occ));
        chk("lat_err", 128'(lat_err), 128'(exp_lerr));
        for (int p = 0; p < 3; p++) begin
            logic [6:0]   q;
            int           best;
            bit           rdy;
            logic [127:0] bv;
            bit           eh, es;
            logic [127:0] ed;
            logic         ah, as_;
            logic [127:0] ad;
            q = (p == 0) ? cur.qa : (p == 1) ? cur.qb : cur.qc;
            best = DEPTH + 1; rdy = 0; bv = '0;
            foreach (mq[i]) begin
                int age;
                age = cyc - mq[i].t;
                if (mq[i].addr == q && age < best) begin
                    best = age; rdy = (age >= mq[i].lat); bv = mq[i].val;
                end
            end
            eh = (best <= DEPTH) && rdy;
            es = (best <= DEPTH) && !rdy;
            ed = eh ? bv : '0;
            case (p)
                0: begin ah = qa_hit; as_ = qa_stall; ad = qa_data; end
                1: begin ah = qb_hit; as_ = qb_stall; ad = qb_data; end
                default: begin ah = qc_hit; as_ = qc_stall; ad = qc_data; end
            endcase
            chk($sformatf("q%0d_hit", p), 128'(ah), 128'(eh));
            chk($sformatf("q%0d_stall", p), 128'(as_), 128'(es));
            chk($sformatf("q%0d_data", p), ad, ed);
        end
    endtask

    task automatic model_update();
        if (cur.rst) begin
            mq.delete();
            exp_occ = 0;
            exp_lerr = 0;
        end else begin
            ent_t keep[$];
            foreach (mq[i]) begin
                int age;
                age = cyc - mq[i].t;
                if (age < DEPTH && !(cur.fl && age < mq[i].lat))
                    keep.push_back(mq[i]);
            end
            mq = keep;
            if (cur.v && !cur.fl) begin
                ent_t e;
                int   l;
                l = int'(cur.lat);
                if (l == 0) l = 1;
                else if (l > DEPTH) l = DEPTH;
                e = '{t: cyc, val: cur.val, addr: cur.addr, lat: l,
                      uid: cur.uid};
                mq.push_back(e);
            end
            exp_lerr = cur.v && (cur.lat == 0 || int'(cur.lat) > DEPTH);
            exp_occ = mq.size();
        end
        cyc++;
    endtask

    task automatic begin_cycle();
        reset = cur.rst; in_valid = cur.v; in_rt_value = cur.val;
        in_rt_addr = cur.addr; in_latency = cur.lat; in_unit_id = cur.uid;
        flush = cur.fl; qa_addr = cur.qa; qb_addr = cur.qb; qc_addr = cur.qc;
        @(negedge clock);
        model_check();
    endtask

    task automatic end_cycle();
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic run(stim_t s);
        cur = s;
        begin_cycle();
        end_cycle();
    endtask

    task automatic do_reset();
        stim_t s;
        s = idle();
        s.rst = 1;
        run(s);
        run(s);
    endtask

    row_t rows [9];
    logic [127:0] vals [20];

    initial begin
        logic [127:0] v1, v2;
        cur = idle();
        reset = 1; in_valid = 0; in_rt_value = '0; in_rt_addr = '0;
        in_latency = '0; in_unit_id = '0; flush = 0;
        qa_addr = '0; qb_addr = '0; qc_addr = '0;
        repeat (3) @(posedge clock);
        #1;

        // Single result, latency 3, tracked cycle by cycle.
        rows[0] = '{v: 1, hit: 0, stall: 0, wb: 0, occ: 0};
        rows[1] = '{v: 0, hit: 0, stall: 1, wb: 0, occ: 1};
        rows[2] = '{v: 0, hit: 0, stall: 1, wb: 0, occ: 1};
        rows[3] = '{v: 0, hit: 1, stall: 0, wb: 0, occ: 1};
        rows[4] = '{v: 0, hit: 1, stall: 0, wb: 0, occ: 1};
        rows[5] = '{v: 0, hit: 1, stall: 0, wb: 0, occ: 1};
        rows[6] = '{v: 0, hit: 1, stall: 0, wb: 0, occ: 1};
        rows[7] = '{v: 0, hit: 1, stall: 0, wb: 1, occ: 1};
        rows[8] = '{v: 0, hit: 0, stall: 0, wb: 0, occ: 0};
        do_reset();
        v1 = {4{32'h1111_1111}};
        for (int c = 0; c < 9; c++) begin
            cur = rows[c].v ? push(7'd5, 4'd3, v1, 3'd1) : idle();
            cur.qa = 7'd5;
            begin_cycle();
            if (c == 0) begin
                chk("rst_wb_addr", 128'(wb_addr), 128'(0));
                chk("rst_wb_unit", 128'(wb_unit_id), 128'(0));
                chk("rst_wb_data", 128'(wb_data), 128'(0));
                chk("rst_lat_err", 128'(lat_err), 128'(0));
            end
            chk("t1_hit", 128'(qa_hit), 128'(rows[c].hit));
            chk("t1_stall", 128'(qa_stall), 128'(rows[c].stall));
            chk("t1_data", 128'(qa_data), rows[c].hit ? v1 : 128'(0));
            chk("t1_wb_en", 128'(wb_en), 128'(rows[c].wb));
            if (rows[c].wb)
                chk("t1_wb_addr", 128'(wb_addr), 128'(5));
            chk("t1_occ", 128'(occupancy), 128'(rows[c].occ));
            end_cycle();
        end

        // Younger unready duplicate masks older ready one.
        do_reset();
        v1 = {4{32'hA5A5_0001}};
        v2 = {4{32'h5A5A_0002}};
        for (int c = 0; c < 10; c++) begin
            cur = (c == 0) ? push(7'd9, 4'd2, v1, 3'd2) :
                  (c == 1) ? push(7'd9, 4'd6, v2, 3'd3) : idle();
            cur.qb = 7'd9;
            begin_cycle();
            if (c >= 2 && c <= 6) begin
                chk("t2_stall", 128'(qb_stall), 128'(1));
                chk("t2_hit", 128'(qb_hit), 128'(0));
            end
            if (c == 7 || c == 8) begin
                chk("t2_wb_en", 128'(wb_en), 128'(1));
                chk("t2_wb_data", 128'(wb_data), (c == 7) ? v1 : v2);
            end
            end_cycle();
        end

        // Illegal latencies clamp and pulse lat_err.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            cur = (c == 0) ? push(7'd20, 4'd0, 128'h20, 3'd4) :
                  (c == 1) ? push(7'd21, 4'd12, 128'h21, 3'd5) : idle();
            cur.qa = 7'd20;
            cur.qb = 7'd21;
            begin_cycle();
            if (c == 1) chk("t3_qa_hit", 128'(qa_hit), 128'(1));
            if (c >= 1 && c <= 3)
                chk("t3_lat_err", 128'(lat_err), 128'(c <= 2));
            if (c == 7) chk("t3_qb_stall", 128'(qb_stall), 128'(1));
            if (c == 8) chk("t3_qb_hit", 128'(qb_hit), 128'(1));
            end_cycle();
        end

        // Flush keeps only the ready entry and drops concurrent input.
        do_reset();
        for (int c = 0; c < 13; c++) begin
            case (c)
                0: cur = push(7'd30, 4'd7, 128'h30, 3'd0);
                1: cur = push(7'd31, 4'd2, 128'h31, 3'd1);
                2: cur = push(7'd32, 4'd7, 128'h32, 3'd2);
                4: begin
                    cur = push(7'd33, 4'd1, 128'h33, 3'd3);
                    cur.fl = 1;
                end
                default: cur = idle();
            endcase
            cur.qa = 7'd31;
            begin_cycle();
            if (c == 4) chk("t4_occ_pre", 128'(occupancy), 128'(3));
            if (c == 5) chk("t4_occ_post", 128'(occupancy), 128'(1));
            if (c >= 5) chk("t4_wb_en", 128'(wb_en), 128'(c == 8));
            if (c == 8) chk("t4_wb_addr", 128'(wb_addr), 128'(31));
            end_cycle();
        end

        // Streaming: occupancy saturates, one writeback per cycle.
        do_reset();
        for (int c = 0; c < 28; c++) begin
            if (c < 20) begin
                vals[c] = {$urandom, $urandom, $urandom, $urandom};
                cur = push(7'(40 + c % 5), 4'(1 + $urandom % 7), vals[c],
                           3'(c % 8));
            end else begin
                cur = idle();
            end
            cur.qa = 7'(40 + $urandom % 5);
            cur.qb = 7'd42;
            cur.qc = 7'd44;
            begin_cycle();
            if (c <= 20)
                chk("t5_occ", 128'(occupancy), 128'((c < 7) ? c : 7));
            if (c >= 7) chk("t5_wb_en", 128'(wb_en), 128'(c <= 26));
            if (c >= 7 && c <= 26)
                chk("t5_wb_data", 128'(wb_data), vals[c-7]);
            end_cycle();
        end

        // Reset mid-flight discards everything.
        do_reset();
        for (int c = 0; c < 13; c++) begin
            if (c < 3) cur = push(7'(50 + c), 4'd7, 128'(c + 1), 3'd6);
            else cur = idle();
            cur.rst = (c == 3);
            cur.qa = 7'd50;
            begin_cycle();
            if (c == 3) chk("t6_occ_pre", 128'(occupancy), 128'(3));
            if (c >= 4) begin
                chk("t6_occ", 128'(occupancy), 128'(0));
                chk("t6_wb_en", 128'(wb_en), 128'(0));
            end
            end_cycle();
        end

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            cur = idle();
            cur.rst = ($urandom % 150) == 0;
            cur.v = ($urandom % 4) != 0;
            cur.val = {$urandom, $urandom, $urandom, $urandom};
            cur.addr = 7'($urandom % 8);
            cur.lat = 4'($urandom % 16);
            cur.uid = 3'($urandom % 8);
            cur.fl = ($urandom % 16) == 0;
            cur.qa = 7'($urandom % 8);
            cur.qb = 7'($urandom % 8);
            cur.qc = 7'($urandom % 8);
            run(cur);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
